sdram_port_arbiter: RTL and testbench
=====================================

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  NUM_CH, 4, requester channel count (2..8).
  ADDR_W, 24, SDRAM word-address width.
  LEN_W, 10, burst-length width.
  ARB_MODE, 1, 0 = fixed priority (ch0 highest), 1 = round robin.
  ACK_TIMEOUT, 1023, max cycles in ISSUE waiting for ack.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
  clk  in  1  controller clock; sole clock.
  rst  in  1  asynchronous, active-high reset.
  sdram_init_done  in  1  controller initialised; no arbitration while low.
  ch_req  in  NUM_CH  per-channel transfer request, level.
  ch_we  in  NUM_CH  1 = write, 0 = read; sampled at grant.
  ch_min_addr  in  NUM_CH*ADDR_W  region start, channel i at [i*ADDR_W +: ADDR_W].
  ch_max_addr  in  NUM_CH*ADDR_W  region end, inclusive.
  ch_len  in  NUM_CH*LEN_W  burst length, 1..2^LEN_W-1.
  ch_load  in  NUM_CH  pulse: reset channel address to ch_min_addr.
  ch_grant  out  NUM_CH  one-hot owner of current transaction.
  ch_done  out  NUM_CH  1-cycle pulse at transaction end.
  ch_err  out  NUM_CH  1-cycle pulse on ack timeout.
  sdram_wr_req / sdram_rd_req  out  1  controller requests.
  sdram_wr_ack / sdram_rd_ack  in  1  controller acks, high for burst duration.
  sdram_wr_addr / sdram_rd_addr  out  ADDR_W  burst start address.
  sdram_wr_burst / sdram_rd_burst  out  LEN_W  burst length.

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE, XFER, DONE.
REQ-004 IDLE: if sdram_init_done and any ch_req, SHALL select winner, register ch_grant, address, length, direction, enter ISSUE next cycle; else stay.
REQ-005 ARB_MODE 0 SHALL grant lowest-index requester; ARB_MODE 1 SHALL grant first requester at or after rr_ptr, wrapping modulo NUM_CH.
REQ-006 rr_ptr SHALL become (winner+1) mod NUM_CH in DONE; unchanged on timeout.
REQ-007 ISSUE: SHALL assert exactly one of sdram_wr_req/sdram_rd_req per latched direction; other held 0.
REQ-008 ISSUE: on matching ack high SHALL go XFER and drop req the following cycle.
REQ-009 XFER: on matching ack low SHALL go DONE.
REQ-010 DONE: SHALL pulse ch_done[winner] one cycle, clear ch_grant, update channel address, return IDLE; min request-to-request gap 1 idle cycle.
REQ-011 Address update: if addr + 2*len <= max + 1 then addr += len, else addr = min; arithmetic in ADDR_W+1 bits, no overflow.
REQ-012 ch_load[i] SHALL set addr[i] = ch_min_addr[i] next cycle; if channel i owns the active transaction, load SHALL be recorded and applied in DONE instead of the increment.
REQ-013 Load and DONE same cycle, same channel: load wins.
REQ-014 Timeout counter SHALL count ISSUE cycles; at ACK_TIMEOUT without ack SHALL drop req, pulse ch_err[winner], keep address, go IDLE.
REQ-015 ch_req deassertion after grant SHALL NOT abort a transaction.
REQ-016 sdram_init_done falling mid-transaction SHALL NOT abort; blocks only new grants.
REQ-017 Address/burst outputs SHALL stay stable from ISSUE entry through DONE.

Reset
REQ-018 rst high SHALL asynchronously force IDLE; all req, grant, done, err outputs 0; addresses, bursts, rr_ptr, timeout counter 0; pending loads cleared.
REQ-019 First cycle after rst release SHALL be IDLE; channel addresses valid only after ch_load per channel.

Verification
REQ-020 NUM_CH=4, RR, all req, we=1010, len=8, acks 8 cycles after req -> grants 0,1,2,3,0; ch1/ch3 use wr port, ch0/ch2 rd port.
REQ-021 ARB_MODE=0, ch0 and ch3 req continuously -> ch3 never granted; ch0 done every transaction.
REQ-022 min=0, max=31, len=8, loaded -> addresses 0,8,16,24,0 (wrap).
REQ-023 ch_load[2] pulsed during ch2 XFER at addr 16 -> next ch2 burst at min, not 24.
REQ-024 ACK_TIMEOUT=15, no ack -> req drops after 15 ISSUE cycles, ch_err pulse, same address reissued next grant.
REQ-025 rst asserted in XFER -> outputs 0 same cycle, IDLE after release, no ch_done.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Multi-channel arbiter in front of an SDRAM controller: picks one requester,
// issues a single burst on the read or write port and walks each channel's address ring.
module sdram_port_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int ADDR_W      = 24,
    parameter int LEN_W       = 10,
    parameter int ARB_MODE    = 1,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sdram_init_done,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_we,
    input  logic [NUM_CH*ADDR_W-1:0] ch_min_addr,
    input  logic [NUM_CH*ADDR_W-1:0] ch_max_addr,
    input  logic [NUM_CH*LEN_W-1:0]  ch_len,
    input  logic [NUM_CH-1:0]        ch_load,
    output logic [NUM_CH-1:0]        ch_grant,
    output logic [NUM_CH-1:0]        ch_done,
    output logic [NUM_CH-1:0]        ch_err,
    output logic                     sdram_wr_req,
    input  logic                     sdram_wr_ack,
    output logic [ADDR_W-1:0]        sdram_wr_addr,
    output logic [LEN_W-1:0]         sdram_wr_burst,
    output logic                     sdram_rd_req,
    input  logic                     sdram_rd_ack,
    output logic [ADDR_W-1:0]        sdram_rd_addr,
    output logic [LEN_W-1:0]         sdram_rd_burst,
    output logic [1:0]               dbg_state
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    burst_q, burst_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [NUM_CH-1:0]   err_q, err_d;
    logic [NUM_CH-1:0]   load_pend_q, load_pend_d;
    logic [ADDR_W-1:0]   ch_addr_q [NUM_CH];
    logic [ADDR_W-1:0]   ch_addr_d [NUM_CH];

    logic [ADDR_W-1:0]   min_arr [NUM_CH];
    logic [ADDR_W-1:0]   max_arr [NUM_CH];
    logic [LEN_W-1:0]    len_arr [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign min_arr[g] = ch_min_addr[g*ADDR_W +: ADDR_W];
        assign max_arr[g] = ch_max_addr[g*ADDR_W +: ADDR_W];
        assign len_arr[g] = ch_len[g*LEN_W +: LEN_W];
    end

    // Round robin scans from rr_ptr upward with wrap; fixed priority scans from ch0.
    logic             arb_found;
    logic [IDX_W-1:0] arb_idx;
    logic [IDX_W-1:0] cand_idx;
    int               cand;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = (ARB_MODE != 0) ? int'(rr_ptr_q) + k : k;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            cand_idx = IDX_W'(cand);
            if (!arb_found && ch_req[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

    // Handshake: the selected req stays high through ISSUE until its ack rises;
    // the controller holds ack high for the whole burst and its fall ends XFER.
    logic ack_sel;
    logic tmo_fire;

    assign ack_sel  = we_q ? sdram_wr_ack : sdram_rd_ack;
    assign tmo_fire = (state_q == ISSUE) && !ack_sel && (tmo_q == TMO_W'(ACK_TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        win_d    = win_q;
        rr_ptr_d = rr_ptr_q;
        we_d     = we_q;
        addr_d   = addr_q;
        burst_d  = burst_q;
        tmo_d    = tmo_q;
        err_d    = '0;
        case (state_q)
            IDLE: begin
                if (sdram_init_done && arb_found) begin
                    state_d          = ISSUE;
                    grant_d          = '0;
                    grant_d[arb_idx] = 1'b1;
                    win_d            = arb_idx;
                    we_d             = ch_we[arb_idx];
                    addr_d           = ch_addr_q[arb_idx];
                    burst_d          = len_arr[arb_idx];
                    tmo_d            = '0;
                end
            end
            ISSUE: begin
                if (ack_sel) begin
                    state_d = XFER;
                end else if (tmo_fire) begin
                    state_d = IDLE;
                    grant_d = '0;
                    err_d   = grant_q;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            XFER: begin
                if (!ack_sel) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d  = IDLE;
                grant_d  = '0;
                rr_ptr_d = (win_q == IDX_W'(NUM_CH - 1)) ? '0 : win_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Ring step: advance by len only if a full further burst still fits below max.
    logic [ADDR_W:0]   cur_ext, step2, limit;
    logic              fits;
    logic [ADDR_W-1:0] incr_addr;
    logic              txn_end;
    logic [NUM_CH-1:0] own;

    assign cur_ext   = {1'b0, ch_addr_q[win_q]};
    assign step2     = (ADDR_W + 1)'({burst_q, 1'b0});
    assign limit     = {1'b0, max_arr[win_q]} + 1'b1;
    assign fits      = (cur_ext + step2) <= limit;
    assign incr_addr = ch_addr_q[win_q] + ADDR_W'(burst_q);

    always_comb begin
        txn_end = (state_q == DONE) || tmo_fire;
        own     = grant_q | ((state_q == IDLE) ? grant_d : '0);
        for (int i = 0; i < NUM_CH; i++) begin
            ch_addr_d[i]   = ch_addr_q[i];
            load_pend_d[i] = load_pend_q[i];
            if (txn_end && grant_q[i]) begin
                // A load recorded during the transaction (or arriving now) beats the step.
                load_pend_d[i] = 1'b0;
                if (ch_load[i] || load_pend_q[i]) begin
                    ch_addr_d[i] = min_arr[i];
                end else if (state_q == DONE) begin
                    ch_addr_d[i] = fits ? incr_addr : min_arr[i];
                end
            end else if (own[i]) begin
                if (ch_load[i]) begin
                    load_pend_d[i] = 1'b1;
                end
            end else if (ch_load[i]) begin
                ch_addr_d[i] = min_arr[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            win_q       <= '0;
            rr_ptr_q    <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            burst_q     <= '0;
            tmo_q       <= '0;
            err_q       <= '0;
            load_pend_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                ch_addr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            win_q       <= win_d;
            rr_ptr_q    <= rr_ptr_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            burst_q     <= burst_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            load_pend_q <= load_pend_d;
            for (int i = 0; i < NUM_CH; i++) begin
                ch_addr_q[i] <= ch_addr_d[i];
            end
        end
    end

    assign ch_grant       = grant_q;
    assign ch_done        = (state_q == DONE) ? grant_q : '0;
    assign ch_err         = err_q;
    assign sdram_wr_req   = (state_q == ISSUE) && we_q;
    assign sdram_rd_req   = (state_q == ISSUE) && !we_q;
    assign sdram_wr_addr  = addr_q;
    assign sdram_rd_addr  = addr_q;
    assign sdram_wr_burst = burst_q;
    assign sdram_rd_burst = burst_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: a round-robin instance and a fixed-priority
// instance, each answered by a simple controller model that acks after a fixed delay.
module tb_sdram_port_arbiter;

    localparam int NCH     = 4;
    localparam int AW      = 24;
    localparam int LW      = 10;
    localparam int TMO     = 15;
    localparam int ACK_DLY = 8;
    localparam int ACK_LEN = 8;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // shared inputs
    logic            init_done;
    logic [NCH-1:0]  we, load;
    logic [NCH*AW-1:0] min_a, max_a;
    logic [NCH*LW-1:0] len_a;

    // round-robin instance
    logic [NCH-1:0] req, grant, done, err;
    logic           wr_req, rd_req, wr_ack, rd_ack;
    logic [AW-1:0]  wr_addr, rd_addr;
    logic [LW-1:0]  wr_burst, rd_burst;
    logic [1:0]     state;

    // fixed-priority instance
    logic [NCH-1:0] fp_req, fp_grant, fp_done, fp_err;
    logic           fp_wr_req, fp_rd_req, fp_wr_ack, fp_rd_ack;
    logic [AW-1:0]  fp_wr_addr, fp_rd_addr;
    logic [LW-1:0]  fp_wr_burst, fp_rd_burst;
    logic [1:0]     fp_state;

    int checks = 0;
    int errors = 0;
    bit ack_en = 1'b1;
    int fp_g3_seen = 0;
    logic [AW-1:0] exp_q[$];

    sdram_port_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .LEN_W(LW), .ARB_MODE(1), .ACK_TIMEOUT(TMO)) u_rr (
        .clk(clk), .rst(rst), .sdram_init_done(init_done),
        .ch_req(req), .ch_we(we), .ch_min_addr(min_a), .ch_max_addr(max_a),
        .ch_len(len_a), .ch_load(load),
        .ch_grant(grant), .ch_done(done), .ch_err(err),
        .sdram_wr_req(wr_req), .sdram_wr_ack(wr_ack), .sdram_wr_addr(wr_addr), .sdram_wr_burst(wr_burst),
        .sdram_rd_req(rd_req), .sdram_rd_ack(rd_ack), .sdram_rd_addr(rd_addr), .sdram_rd_burst(rd_burst),
        .dbg_state(state)
    );

    sdram_port_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .LEN_W(LW), .ARB_MODE(0), .ACK_TIMEOUT(TMO)) u_fp (
        .clk(clk), .rst(rst), .sdram_init_done(init_done),
        .ch_req(fp_req), .ch_we(we), .ch_min_addr(min_a), .ch_max_addr(max_a),
        .ch_len(len_a), .ch_load(load),
        .ch_grant(fp_grant), .ch_done(fp_done), .ch_err(fp_err),
        .sdram_wr_req(fp_wr_req), .sdram_wr_ack(fp_wr_ack), .sdram_wr_addr(fp_wr_addr), .sdram_wr_burst(fp_wr_burst),
        .sdram_rd_req(fp_rd_req), .sdram_rd_ack(fp_rd_ack), .sdram_rd_addr(fp_rd_addr), .sdram_rd_burst(fp_rd_burst),
        .dbg_state(fp_state)
    );

    // controller model for the round-robin instance
    initial begin : rr_responder
        bit is_wr;
        wr_ack = 1'b0;
        rd_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_en && !rst && (wr_req || rd_req)) begin
                is_wr = wr_req;
                repeat (ACK_DLY - 1) @(negedge clk);
                if (is_wr) wr_ack = 1'b1; else rd_ack = 1'b1;
                repeat (ACK_LEN) @(negedge clk);
                wr_ack = 1'b0;
                rd_ack = 1'b0;
            end
        end
    end

    // controller model for the fixed-priority instance
    initial begin : fp_responder
        bit is_wr;
        fp_wr_ack = 1'b0;
        fp_rd_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && (fp_wr_req || fp_rd_req)) begin
                is_wr = fp_wr_req;
                repeat (ACK_DLY - 1) @(negedge clk);
                if (is_wr) fp_wr_ack = 1'b1; else fp_rd_ack = 1'b1;
                repeat (ACK_LEN) @(negedge clk);
                fp_wr_ack = 1'b0;
                fp_rd_ack = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (fp_grant[3] === 1'b1) fp_g3_seen++;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic do_reset_load();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        fp_req = '0;
        @(negedge clk);
        rst = 1'b0;
        load = '1;
        @(negedge clk);
        load = '0;
        @(negedge clk);
    endtask

    task automatic wait_issue(input bit fp, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (fp ? (fp_wr_req || fp_rd_req) : (wr_req || rd_req)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input bit fp, output logic [NCH-1:0] d, output bit ok);
        ok = 1'b0;
        d = '0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (fp ? (|fp_done) : (|done)) begin
                d = fp ? fp_done : done;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_state(input logic [1:0] s, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (state === s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // tests
    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (grant !== '0) begin $display("FAIL reset_grant got=%b exp=0000", grant); errors++; end
        checks++; if (done !== '0 || err !== '0) begin $display("FAIL reset_done_err got=%b/%b exp=0", done, err); errors++; end
        checks++; if (wr_req !== 1'b0 || rd_req !== 1'b0) begin $display("FAIL reset_req got=%b%b exp=00", wr_req, rd_req); errors++; end
        checks++; if (wr_addr !== '0 || rd_burst !== '0) begin $display("FAIL reset_addr_burst got=%h/%h exp=0", wr_addr, rd_burst); errors++; end
        checks++; if (fp_grant !== '0 || fp_state !== 2'd0) begin $display("FAIL reset_fp got=%b/%0d exp=0", fp_grant, fp_state); errors++; end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (state !== 2'd0) begin $display("FAIL reset_release_state got=%0d exp=0", state); errors++; end
    endtask

    task automatic test_round_robin();
        bit ok;
        int ch;
        logic [NCH-1:0] d;
        logic [AW-1:0] exp_a, got_a;
        logic [LW-1:0] got_b;
        do_reset_load();
        for (int k = 0; k < 17; k++) exp_q.push_back(AW'((k % 4) * 256 + 8 * ((k / 4) % 4)));
        init_done = 1'b1;
        req = '1;
        for (int k = 0; k < 17; k++) begin
            ch = k % 4;
            wait_issue(1'b0, ok);
            checks++; if (!ok) begin $display("FAIL rr_issue_wait k=%0d no request within bound", k); errors++; break; end
            exp_a = exp_q.pop_front();
            got_a = wr_req ? wr_addr : rd_addr;
            got_b = wr_req ? wr_burst : rd_burst;
            checks++; if (grant !== (NCH'(1) << ch)) begin $display("FAIL rr_grant k=%0d got=%b exp_ch=%0d", k, grant, ch); errors++; end
            checks++; if (wr_req !== we[ch] || rd_req !== !we[ch]) begin $display("FAIL rr_port k=%0d got wr=%b rd=%b exp_we=%b", k, wr_req, rd_req, we[ch]); errors++; end
            checks++; if (got_a !== exp_a) begin $display("FAIL rr_addr k=%0d got=%0d exp=%0d", k, got_a, exp_a); errors++; end
            checks++; if (got_b !== 10'd8) begin $display("FAIL rr_burst k=%0d got=%0d exp=8", k, got_b); errors++; end
            wait_done(1'b0, d, ok);
            checks++; if (!ok || d !== (NCH'(1) << ch)) begin $display("FAIL rr_done k=%0d got=%b exp_ch=%0d", k, d, ch); errors++; end
            if (k == 16) req = '0;
        end
    endtask

    task automatic test_fixed_priority();
        bit ok;
        logic [NCH-1:0] d;
        logic [AW-1:0] exp_a;
        do_reset_load();
        for (int k = 0; k < 5; k++) exp_q.push_back(AW'(8 * (k % 4)));
        init_done = 1'b1;
        fp_req = 4'b1001;
        for (int k = 0; k < 5; k++) begin
            wait_issue(1'b1, ok);
            checks++; if (!ok) begin $display("FAIL fp_issue_wait k=%0d no request within bound", k); errors++; break; end
            exp_a = exp_q.pop_front();
            checks++; if (fp_grant !== 4'b0001 || fp_rd_req !== 1'b1) begin $display("FAIL fp_grant k=%0d got=%b rd=%b exp=0001 rd=1", k, fp_grant, fp_rd_req); errors++; end
            checks++; if (fp_rd_addr !== exp_a) begin $display("FAIL fp_addr k=%0d got=%0d exp=%0d", k, fp_rd_addr, exp_a); errors++; end
            wait_done(1'b1, d, ok);
            checks++; if (!ok || d !== 4'b0001) begin $display("FAIL fp_done k=%0d got=%b exp=0001", k, d); errors++; end
            if (k == 4) fp_req = '0;
        end
        checks++; if (fp_g3_seen != 0) begin $display("FAIL fp_ch3_starved got=%0d grants exp=0", fp_g3_seen); errors++; end
    endtask

    task automatic test_load_in_xfer();
        bit ok;
        logic [NCH-1:0] d;
        logic [AW-1:0] exp_a;
        do_reset_load();
        exp_q.push_back(24'd512); exp_q.push_back(24'd520); exp_q.push_back(24'd528);
        exp_q.push_back(24'd512); exp_q.push_back(24'd520); exp_q.push_back(24'd512);
        init_done = 1'b1;
        ack_en = 1'b1;
        req = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            wait_issue(1'b0, ok);
            checks++; if (!ok) begin $display("FAIL load_issue_wait k=%0d no request within bound", k); errors++; break; end
            exp_a = exp_q.pop_front();
            checks++; if (rd_addr !== exp_a) begin $display("FAIL load_addr k=%0d got=%0d exp=%0d", k, rd_addr, exp_a); errors++; end
            if (k == 2) begin
                wait_state(2'd2, ok);
                checks++; if (!ok) begin $display("FAIL load_xfer_wait k=%0d no XFER within bound", k); errors++; end
                load = 4'b0100;
                @(negedge clk);
                load = '0;
            end
            wait_done(1'b0, d, ok);
            checks++; if (!ok || d !== 4'b0100) begin $display("FAIL load_done k=%0d got=%b exp=0100", k, d); errors++; end
            if (k == 4) begin
                load = 4'b0100;
                @(negedge clk);
                load = '0;
            end
            if (k == 5) req = '0;
        end
    endtask

    task automatic test_init_done();
        bit ok;
        int ng;
        logic [NCH-1:0] d;
        do_reset_load();
        init_done = 1'b1;
        ack_en = 1'b1;
        req = 4'b0010;
        wait_issue(1'b0, ok);
        checks++; if (!ok || wr_addr !== 24'd256) begin $display("FAIL init_first_issue got ok=%b addr=%0d exp addr=256", ok, wr_addr); errors++; end
        req = '0;
        init_done = 1'b0;
        wait_done(1'b0, d, ok);
        checks++; if (!ok || d !== 4'b0010) begin $display("FAIL init_no_abort got=%b exp=0010", d); errors++; end
        req = 4'b0010;
        ng = 0;
        repeat (20) begin
            @(negedge clk);
            if (|grant) ng++;
        end
        checks++; if (ng != 0) begin $display("FAIL init_blocks_grant got=%0d grant cycles exp=0", ng); errors++; end
        init_done = 1'b1;
        wait_issue(1'b0, ok);
        checks++; if (!ok || grant !== 4'b0010 || wr_addr !== 24'd264) begin $display("FAIL init_resume got grant=%b addr=%0d exp 0010/264", grant, wr_addr); errors++; end
        wait_done(1'b0, d, ok);
        req = '0;
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        logic [NCH-1:0] d;
        do_reset_load();
        init_done = 1'b1;
        ack_en = 1'b1;
        req = 4'b0001;
        wait_issue(1'b0, ok);
        wait_done(1'b0, d, ok);
        ack_en = 1'b0;
        wait_issue(1'b0, ok);
        checks++; if (!ok || rd_addr !== 24'd8) begin $display("FAIL tmo_first_addr got ok=%b addr=%0d exp=8", ok, rd_addr); errors++; end
        n = 1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!rd_req) break;
            n++;
        end
        checks++; if (n != TMO) begin $display("FAIL tmo_issue_cycles got=%0d exp=%0d", n, TMO); errors++; end
        checks++; if (err !== 4'b0001) begin $display("FAIL tmo_err got=%b exp=0001", err); errors++; end
        checks++; if (done !== '0) begin $display("FAIL tmo_no_done got=%b exp=0000", done); errors++; end
        ack_en = 1'b1;
        @(negedge clk);
        checks++; if (err !== '0) begin $display("FAIL tmo_err_pulse got=%b exp=0000", err); errors++; end
        checks++; if (rd_req !== 1'b1 || grant !== 4'b0001 || rd_addr !== 24'd8) begin $display("FAIL tmo_reissue got req=%b grant=%b addr=%0d exp 1/0001/8", rd_req, grant, rd_addr); errors++; end
        wait_done(1'b0, d, ok);
        checks++; if (!ok || d !== 4'b0001) begin $display("FAIL tmo_reissue_done got=%b exp=0001", d); errors++; end
        req = '0;
    endtask

    task automatic test_reset_in_xfer();
        bit ok;
        int nd;
        do_reset_load();
        init_done = 1'b1;
        ack_en = 1'b1;
        req = 4'b0001;
        wait_issue(1'b0, ok);
        wait_state(2'd2, ok);
        checks++; if (!ok) begin $display("FAIL rstx_xfer_wait no XFER within bound"); errors++; end
        rst = 1'b1;
        #1;
        checks++; if (grant !== '0 || done !== '0) begin $display("FAIL rstx_grant_done got=%b/%b exp=0", grant, done); errors++; end
        checks++; if (wr_req !== 1'b0 || rd_req !== 1'b0) begin $display("FAIL rstx_req got=%b%b exp=00", wr_req, rd_req); errors++; end
        checks++; if (state !== 2'd0 || rd_addr !== '0 || rd_burst !== '0) begin $display("FAIL rstx_state_addr got=%0d/%0d/%0d exp=0", state, rd_addr, rd_burst); errors++; end
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (20) begin
            @(negedge clk);
            if (|done) nd++;
        end
        checks++; if (nd != 0) begin $display("FAIL rstx_no_done got=%0d pulses exp=0", nd); errors++; end
        checks++; if (state !== 2'd0) begin $display("FAIL rstx_idle got=%0d exp=0", state); errors++; end
    endtask

    initial begin : main
        init_done = 1'b0;
        req = '0;
        fp_req = '0;
        load = '0;
        we = 4'b1010;
        len_a = {4{10'd8}};
        min_a = {24'd768, 24'd512, 24'd256, 24'd0};
        max_a = {24'd799, 24'd543, 24'd287, 24'd31};
        test_reset();
        test_round_robin();
        test_fixed_priority();
        test_load_in_xfer();
        test_init_done();
        test_timeout();
        test_reset_in_xfer();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
